// File: rtl/df_addsub_if.sv
// df_addsub_if: operand/result bundle for df_addsub_pipe.
interface df_addsub_if #(parameter int WIDTH = 9);
    logic en, in_valid, sub, out_valid, carry_out, ovf;
    logic [WIDTH-1:0] a, b, out;
    modport master(output en, in_valid, a, b, sub, input out_valid, out, carry_out, ovf);
    modport slave(input en, in_valid, a, b, sub, output out_valid, out, carry_out, ovf);
endinterface

// File: rtl/df_addsub_pipe.sv
// df_addsub_pipe: carry-split pipelined add/sub, one SEGMENTS slice per stage.
// Define DF_ADDSUB_SAT_EN to saturate the result on signed overflow.
module df_addsub_pipe #(
    parameter int WIDTH    = 9,
    parameter int SEGMENTS = 3
) (
    input logic         clk,
    input logic         rst_n,
    df_addsub_if.slave  bus
);
    localparam int SW = WIDTH / SEGMENTS;
    localparam int L  = SEGMENTS - 1;

    if (WIDTH % SEGMENTS != 0) begin : g_bad
        $error("WIDTH must be a multiple of SEGMENTS");
    end

    logic [SEGMENTS-1:0] v, c, xv, xc, co;
    logic [SEGMENTS-1:0][WIDTH-1:0] pa, pb, ps, xa, xb, xs;
    logic [SEGMENTS-1:0][SW:0] sum;
    logic ovf_d, ovf_q;

    // x* are the inputs each stage sees; xs becomes the next partial result
    always_comb begin
        xa[0] = bus.a;
        xb[0] = bus.b ^ {WIDTH{bus.sub}};
        xc[0] = bus.sub;
        xv[0] = bus.in_valid;
        xs[0] = '0;
        for (int k = 1; k < SEGMENTS; k++) begin
            xa[k] = pa[k-1];
            xb[k] = pb[k-1];
            xc[k] = c[k-1];
            xv[k] = v[k-1];
            xs[k] = ps[k-1];
        end
        for (int k = 0; k < SEGMENTS; k++) begin
            sum[k] = {1'b0, xa[k][k*SW +: SW]} + {1'b0, xb[k][k*SW +: SW]} + {{SW{1'b0}}, xc[k]};
            co[k] = sum[k][SW];
            xs[k][k*SW +: SW] = sum[k][SW-1:0];
        end
        ovf_d = (xa[L][WIDTH-1] == xb[L][WIDTH-1]) && (sum[L][SW-1] != xa[L][WIDTH-1]);
`ifdef DF_ADDSUB_SAT_EN
        if (ovf_d) xs[L] = {xa[L][WIDTH-1], {(WIDTH-1){~xa[L][WIDTH-1]}}};
`endif
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            v     <= '0;
            c     <= '0;
            pa    <= '0;
            pb    <= '0;
            ps    <= '0;
            ovf_q <= 1'b0;
        end else if (bus.en) begin
            v     <= xv;
            c     <= co;
            pa    <= xa;
            pb    <= xb;
            ps    <= xs;
            ovf_q <= ovf_d;
        end

    assign bus.out_valid = v[L];
    assign bus.out       = ps[L];
    assign bus.carry_out = c[L];
    assign bus.ovf       = ovf_q;
endmodule
